// File: rtl/csr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : csr_arbiter_if
// Desc     : Requester-side and controller-side bus bundle of csr_arbiter.
//            slave  = arbiter view, master = requesters + memory controller.
// Revision : 1.0 - initial release
// ============================================================================
interface csr_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      csr_wr_en;
  logic                      csr_rd_en;
  logic [ADDR_W-1:0]         csr_addr;
  logic [DATA_W-1:0]         csr_wr_data;
  logic [DATA_W-1:0]         csr_rd_data;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, csr_rd_data,
    output req_ready, rsp_valid, rsp_rdata,
           csr_wr_en, csr_rd_en, csr_addr, csr_wr_data
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, csr_rd_data,
    input  req_ready, rsp_valid, rsp_rdata,
           csr_wr_en, csr_rd_en, csr_addr, csr_wr_data
  );
endinterface
`default_nettype wire

// File: rtl/csr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : csr_arbiter
// Desc     : Round-robin arbiter sharing one CSR port among NUM_REQ
//            requesters. One transaction every 3 cycles: accept (IDLE),
//            strobe (ISSUE), response pulse (RESP). Read and write strobes
//            are never high together.
// Revision : 1.0 - initial release
// ============================================================================
module csr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
) (
  input  wire logic     clk,
  input  wire logic     rst,
  csr_arbiter_if.slave  bus,
  output logic          busy,
  output logic [2:0]    grant_id
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  // last_grant resets to the top index so requester 0 wins first
  localparam logic [2:0] c_LAST_RST = 3'(NUM_REQ - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [2:0]          r_last_grant;
  logic [2:0]          r_idx;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;

  logic [ADDR_W-1:0]   w_req_addr  [NUM_REQ];
  logic [DATA_W-1:0]   w_req_wdata [NUM_REQ];
  logic                w_found;
  logic                w_accept;
  logic [2:0]          w_winner;
  logic                w_sel_write;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  int                  w_dist;
  int                  w_best;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_req_addr[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
    assign w_req_wdata[g] = bus.req_wdata[g*DATA_W +: DATA_W];
  end

  // Round-robin pick: the valid requester closest above last_grant (wrapping) wins
  always_comb begin
    w_found     = 1'b0;
    w_winner    = r_last_grant;
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_dist      = 0;
    w_best      = NUM_REQ;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_dist = j - int'(r_last_grant) - 1;
      if (w_dist < 0) begin
        w_dist = w_dist + NUM_REQ;
      end
      if (bus.req_valid[j] && (w_dist < w_best)) begin
        w_best      = w_dist;
        w_found     = 1'b1;
        w_winner    = 3'(j);
        w_sel_write = bus.req_write[j];
        w_sel_addr  = w_req_addr[j];
        w_sel_wdata = w_req_wdata[j];
      end
    end
  end

  // A request seen while rst is high must not be accepted
  assign w_accept = (r_state == S_IDLE) && w_found && !rst;

  // Next-state and combinational outputs: ready pulse in IDLE, strobe in ISSUE
  always_comb begin
    w_next_state  = r_state;
    bus.req_ready = '0;
    bus.csr_wr_en = 1'b0;
    bus.csr_rd_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = S_ISSUE;
          for (int j = 0; j < NUM_REQ; j++) begin
            bus.req_ready[j] = (w_winner == 3'(j));
          end
        end
      end
      S_ISSUE: begin
        bus.csr_wr_en = r_write;
        bus.csr_rd_en = !r_write;
        w_next_state  = S_RESP;
      end
      S_RESP: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch the winner's request at acceptance; capture read data during ISSUE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= c_LAST_RST;
      r_idx        <= '0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
    end else begin
      r_rsp_valid <= '0;
      if (w_accept) begin
        r_write      <= w_sel_write;
        r_addr       <= w_sel_addr;
        r_wdata      <= w_sel_wdata;
        r_idx        <= w_winner;
        r_last_grant <= w_winner;
      end
      if (r_state == S_ISSUE) begin
        r_rsp_rdata <= r_write ? '0 : bus.csr_rd_data;
        for (int j = 0; j < NUM_REQ; j++) begin
          r_rsp_valid[j] <= (r_idx == 3'(j));
        end
      end
    end
  end

  assign bus.csr_addr    = r_addr;
  assign bus.csr_wr_data = r_wdata;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign busy            = (r_state != S_IDLE);
  assign grant_id        = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_csr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_arbiter
// Desc     : Self-checking bench for csr_arbiter (NUM_REQ=3) with a CSR
//            memory model, per-requester op queues and a transaction-level
//            reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_arbiter;
  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [2:0] grant_id;

  csr_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  csr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    oh_idx = -1;
    for (int i = 0; i < N; i++) if (v[i]) oh_idx = i;
  endfunction

  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 16) return 32'h1234ABCD;
    return 32'hC0DE0000 | 32'(a);
  endfunction

  // ---------------- memory controller model ----------------
  logic [DW-1:0] mem [256];
  logic          error_flag = 1'b0;

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = init_word(a);
    forever begin
      @(posedge clk);
      if (bus.csr_wr_en && bus.csr_rd_en) error_flag <= 1'b1;
      if (bus.csr_wr_en) mem[bus.csr_addr] <= bus.csr_wr_data;
    end
  end

  assign bus.csr_rd_data = mem[bus.csr_addr];

  // ---------------- requester driver ----------------
  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  op_t opq [N][$];

  task automatic push(input int r, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    op_t o;
    o.wr = wr; o.addr = a; o.wdata = d;
    opq[r].push_back(o);
  endtask

  initial begin : driver
    logic [N-1:0] acked;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    forever begin
      @(negedge clk);
      acked = bus.req_ready;
      @(posedge clk);
      #1;
      for (int j = 0; j < N; j++) begin
        if (acked[j] && opq[j].size() > 0) void'(opq[j].pop_front());
        if (opq[j].size() > 0) begin
          bus.req_valid[j]           = 1'b1;
          bus.req_write[j]           = opq[j][0].wr;
          bus.req_addr[j*AW +: AW]   = opq[j][0].addr;
          bus.req_wdata[j*DW +: DW]  = opq[j][0].wdata;
        end else begin
          bus.req_valid[j] = 1'b0;
        end
      end
    end
  end

  // ---------------- observation logs (DUT activity) ----------------
  int            acc_cyc[$];
  int            acc_id[$];
  int            str_cyc[$];
  logic          str_wr[$];
  logic [AW-1:0] str_addr[$];
  int            rsp_cyc[$];
  int            rsp_id[$];
  logic [DW-1:0] rsp_dat[$];
  int            busy_cnt = 0;
  int            both_cnt = 0;

  task automatic clear_logs();
    acc_cyc.delete(); acc_id.delete();
    str_cyc.delete(); str_wr.delete(); str_addr.delete();
    rsp_cyc.delete(); rsp_id.delete(); rsp_dat.delete();
    busy_cnt = 0;
    both_cnt = 0;
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [DW-1:0] m_mem [256];

  initial begin : model
    int            m_free, m_last, m_gid, win, jj, t_acc;
    bit            s_pend, s_wr, r_pend, sv;
    int            s_cyc, r_cyc, r_id;
    logic [AW-1:0] s_addr, h_addr;
    logic [DW-1:0] s_wdata, h_wdata, h_rdata;
    logic [N-1:0]  exp_ready, exp_rsp;
    for (int a = 0; a < 256; a++) m_mem[a] = init_word(a);
    m_free = 0; m_last = N - 1; m_gid = 0; t_acc = -10;
    s_pend = 0; r_pend = 0; s_wr = 0; s_cyc = 0; r_cyc = 0; r_id = 0;
    s_addr = '0; s_wdata = '0; h_addr = '0; h_wdata = '0; h_rdata = '0;
    forever begin
      @(negedge clk);
      // expected outputs for this cycle
      exp_ready = '0;
      win = -1;
      if (!rst && cyc >= m_free) begin
        for (int k = 1; k <= N; k++) begin
          jj = (m_last + k) % N;
          if (win < 0 && bus.req_valid[jj]) win = jj;
        end
      end
      if (win >= 0) exp_ready[win] = 1'b1;
      sv = s_pend && (s_cyc == cyc);
      exp_rsp = '0;
      if (r_pend && r_cyc == cyc) exp_rsp[r_id] = 1'b1;

      check("req_ready",   bus.req_ready,   exp_ready);
      check("csr_wr_en",   bus.csr_wr_en,   sv && s_wr);
      check("csr_rd_en",   bus.csr_rd_en,   sv && !s_wr);
      check("csr_addr",    bus.csr_addr,    h_addr);
      check("csr_wr_data", bus.csr_wr_data, h_wdata);
      check("rsp_valid",   bus.rsp_valid,   exp_rsp);
      if (exp_rsp != '0) check("rsp_rdata", bus.rsp_rdata, h_rdata);
      check("busy",        busy,            (t_acc >= 0) && (cyc > t_acc) && (cyc <= t_acc + 2));
      check("grant_id",    grant_id,        3'(m_gid));

      // log observed DUT activity
      if (bus.req_ready != '0) begin acc_cyc.push_back(cyc); acc_id.push_back(oh_idx(bus.req_ready)); end
      if (bus.csr_wr_en || bus.csr_rd_en) begin
        str_cyc.push_back(cyc); str_wr.push_back(bus.csr_wr_en); str_addr.push_back(bus.csr_addr);
      end
      if (bus.rsp_valid != '0) begin
        rsp_cyc.push_back(cyc); rsp_id.push_back(oh_idx(bus.rsp_valid)); rsp_dat.push_back(bus.rsp_rdata);
      end
      if (busy) busy_cnt++;
      if (bus.csr_wr_en && bus.csr_rd_en) both_cnt++;

      // advance the model
      if (sv) begin
        if (s_wr) begin
          m_mem[s_addr] = s_wdata;
          h_rdata = '0;
        end else begin
          h_rdata = m_mem[s_addr];
        end
      end
      if (rst) begin
        m_free = cyc + 1; m_last = N - 1; m_gid = 0; t_acc = -10;
        s_pend = 0; r_pend = 0; h_addr = '0; h_wdata = '0; h_rdata = '0;
      end else if (win >= 0) begin
        m_last = win; m_gid = win; m_free = cyc + 3; t_acc = cyc;
        s_pend = 1; s_cyc = cyc + 1; s_wr = bus.req_write[win];
        s_addr = bus.req_addr[win*AW +: AW]; s_wdata = bus.req_wdata[win*DW +: DW];
        h_addr = s_addr; h_wdata = s_wdata;
        r_pend = 1; r_cyc = cyc + 2; r_id = win;
      end
    end
  end

  // wait until all queued ops are done and the arbiter is idle (bounded)
  task automatic drain(input string name, input int budget);
    int waited;
    waited = 0;
    @(negedge clk);
    while ((opq[0].size() + opq[1].size() + opq[2].size() > 0 || busy || bus.req_valid != '0)
           && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check({name, " completes in budget"}, waited < budget, 1'b1);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : main
    int w;
    int exp_order[6];
    int cnt0;
    exp_order = '{0, 1, 0, 1, 0, 1};

    // reset with requester 0 already requesting: must not be accepted
    push(0, 1'b0, 8'h10, 32'h0);
    repeat (3) @(negedge clk);
    check("reset req_ready",   bus.req_ready,   3'b000);
    check("reset rsp_valid",   bus.rsp_valid,   3'b000);
    check("reset rsp_rdata",   bus.rsp_rdata,   32'h0);
    check("reset csr_addr",    bus.csr_addr,    8'h00);
    check("reset csr_wr_data", bus.csr_wr_data, 32'h0);
    check("reset busy",        busy,            1'b0);
    check("reset grant_id",    grant_id,        3'd0);
    clear_logs();
    @(posedge clk); #1 rst = 1'b0;

    // single read
    drain("single read", 50);
    check("s1 accept count", acc_id.size(), 1);
    if (acc_id.size() == 1 && str_cyc.size() == 1 && rsp_cyc.size() == 1) begin
      check("s1 winner",       acc_id[0], 0);
      check("s1 strobe delay", str_cyc[0] - acc_cyc[0], 1);
      check("s1 strobe read",  str_wr[0], 1'b0);
      check("s1 strobe addr",  str_addr[0], 8'h10);
      check("s1 rsp delay",    rsp_cyc[0] - acc_cyc[0], 2);
      check("s1 rsp id",       rsp_id[0], 0);
      check("s1 rsp data",     rsp_dat[0], 32'h1234ABCD);
    end
    check("s1 busy cycles", busy_cnt, 2);

    // write then read of the same address
    clear_logs();
    push(1, 1'b1, 8'h00, 32'h00000003);
    push(0, 1'b0, 8'h00, 32'h0);
    drain("write then read", 50);
    check("s2 rsp count", rsp_id.size(), 2);
    if (rsp_id.size() == 2 && acc_cyc.size() == 2) begin
      check("s2 write rsp id",   rsp_id[0], 1);
      check("s2 write rsp data", rsp_dat[0], 32'h0);
      check("s2 read rsp id",    rsp_id[1], 0);
      check("s2 read rsp data",  rsp_dat[1], 32'h00000003);
      check("s2 accept spacing", acc_cyc[1] - acc_cyc[0], 3);
    end
    check("s2 mem_start", mem[0][0], 1'b1);
    check("s2 mem_mode",  mem[0][1], 1'b1);

    // reset during ISSUE of a write, then fairness between 0 and 1
    clear_logs();
    push(1, 1'b1, 8'h08, 32'hDEADBEEF);
    w = 0;
    @(negedge clk);
    while (bus.req_ready == '0 && w < 20) begin @(negedge clk); w++; end
    check("s5 write accepted", w < 20, 1'b1);
    for (int k = 0; k < 3; k++) begin
      push(0, 1'b0, 8'(8'h20 + k), 32'h0);
      push(1, 1'b0, 8'(8'h30 + k), 32'h0);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("s5 post-reset rsp_valid", bus.rsp_valid, 3'b000);
    check("s5 post-reset wr_en",     bus.csr_wr_en, 1'b0);
    check("s5 post-reset rd_en",     bus.csr_rd_en, 1'b0);
    check("s5 post-reset csr_addr",  bus.csr_addr,  8'h00);
    check("s5 post-reset busy",      busy,          1'b0);
    check("s5 post-reset grant_id",  grant_id,      3'd0);
    check("s5 first grant to 0",     bus.req_ready, 3'b001);
    drain("fairness", 100);
    check("s5 aborted write strobed", (str_wr.size() > 0) ? str_wr[0] : 1'b0, 1'b1);
    check("s3 accept count", acc_id.size(), 7);
    check("s3 rsp count",    rsp_id.size(), 6);
    if (acc_id.size() == 7 && rsp_id.size() == 6) begin
      check("s5 no rsp for aborted write", rsp_id[0], 0);
      for (int k = 0; k < 6; k++) check("s3 grant order", acc_id[k+1], exp_order[k]);
      for (int k = 1; k < 6; k++) check("s3 accept spacing", acc_cyc[k+1] - acc_cyc[k], 3);
    end

    // sparse requesters 1 and 2 after reset (last_grant = 2)
    pulse_rst();
    clear_logs();
    push(1, 1'b1, 8'h40, 32'h0000A5A5);
    push(2, 1'b0, 8'h40, 32'h0);
    push(1, 1'b0, 8'h10, 32'h0);
    drain("sparse", 60);
    check("s4 accept count", acc_id.size(), 3);
    if (acc_id.size() == 3 && rsp_dat.size() == 3) begin
      check("s4 order 0", acc_id[0], 1);
      check("s4 order 1", acc_id[1], 2);
      check("s4 order 2", acc_id[2], 1);
      check("s4 req2 reads new value", rsp_dat[1], 32'h0000A5A5);
    end
    cnt0 = 0;
    foreach (acc_id[k]) if (acc_id[k] == 0) cnt0++;
    foreach (rsp_id[k]) if (rsp_id[k] == 0) cnt0++;
    check("s4 requester 0 untouched", cnt0, 0);

    // random mix of 200 reads and writes from all requesters
    clear_logs();
    for (int k = 0; k < 200; k++) begin
      push(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), $urandom);
    end
    drain("random", 1000);
    check("s6 accept count",    acc_id.size(), 200);
    check("s6 rsp count",       rsp_id.size(), 200);
    check("s6 strobe overlaps", both_cnt, 0);
    check("s6 error_flag",      error_flag, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
